pc_gen_fq: RTL and testbench

//  Parametrised next-generation PC unit for the RISC-V core. Generates sequential/predicted fetch

---
 rtl/pc_gen_fq_pkg.sv | 22 ++
 rtl/pc_gen_fq_if.sv | 33 +++
 rtl/pc_gen_fq_fifo.sv | 65 ++++++
 rtl/pc_gen_fq.sv | 84 ++++++++
 tb/tb_pc_gen_fq.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/pc_gen_fq_pkg.sv
// Shared constants, helper functions and the next-pc select encoding for the PC generator.
package pc_gen_fq_pkg;

    localparam logic RstEnable = 1'b1;

    typedef enum logic [1:0] {
        PcHold     = 2'd0,
        PcSeq      = 2'd1,
        PcPred     = 2'd2,
        PcRedirect = 2'd3
    } pc_sel_e;

    // FQ entry layout: {pc, pred_taken, pred_target}
    function automatic int unsigned fq_entry_width(input int unsigned xlen);
        return 2 * xlen + 1;
    endfunction

    function automatic int unsigned fq_cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_gen_fq_if.sv
// Fetch-side bundle: redirect/predict inputs, I-cache request handshake and fetch-queue head.
interface pc_gen_fq_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned FQ_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(FQ_DEPTH) + 1;

    logic            rdy;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            pred_valid;
    logic [XLEN-1:0] pred_target;
    logic            req_valid;
    logic [XLEN-1:0] req_pc;
    logic            req_ready;
    logic            fq_valid;
    logic [XLEN-1:0] fq_pc;
    logic            fq_pred_taken;
    logic [XLEN-1:0] fq_pred_target;
    logic            fq_pop;
    logic [CntW-1:0] fq_count;

    modport master (
        input  rdy, redirect_valid, redirect_pc, pred_valid, pred_target, req_ready, fq_pop,
        output req_valid, req_pc, fq_valid, fq_pc, fq_pred_taken, fq_pred_target, fq_count
    );

    modport slave (
        output rdy, redirect_valid, redirect_pc, pred_valid, pred_target, req_ready, fq_pop,
        input  req_valid, req_pc, fq_valid, fq_pc, fq_pred_taken, fq_pred_target, fq_count
    );

endinterface

// File: rtl/pc_gen_fq_fifo.sv
// Synchronous FIFO holding in-flight fetch entries; flush empties it and wins over push/pop.
module pc_gen_fq_fifo
    import pc_gen_fq_pkg::*;
#(
    parameter int unsigned Width = 65,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_eff, pop_eff, full, empty;

    assign full     = (cnt_q == CntW'(Depth));
    assign empty    = (cnt_q == '0);
    assign pop_eff  = pop_i && !flush_i && !empty;
    assign push_eff = push_i && !flush_i && (!full || pop_eff);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally
            if (pop_eff)  rd_d = rd_q + PtrW'(1);
            if (push_eff) wr_d = wr_q + PtrW'(1);
            cnt_d = cnt_q + CntW'(push_eff) - CntW'(pop_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/pc_gen_fq.sv
// PC generator: owns the fetch pc, next-pc mux and I-cache handshake, and logs every issued
// fetch into the in-flight fetch queue read by decode.
module pc_gen_fq
    import pc_gen_fq_pkg::*;
#(
    parameter int unsigned    XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned    INST_BYTES = 4,
    parameter int unsigned    FQ_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst,
    pc_gen_fq_if.master  bus
);
    localparam int unsigned EntryW = fq_entry_width(XLEN);
    localparam int unsigned CntW   = fq_cnt_width(FQ_DEPTH);

    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
        return a & ~(XLEN'(INST_BYTES - 1));
    endfunction

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CntW-1:0]   count;
    logic [EntryW-1:0] wdata, rdata;
    logic              active, redirect, has_room, fire, pop_eff, head_valid;
    pc_sel_e           pc_sel;

    // rdy low freezes every register: all state-changing strobes are qualified by active
    assign active     = !rst && bus.rdy;
    assign redirect   = active && bus.redirect_valid;
    assign has_room   = (count < CntW'(FQ_DEPTH));
    assign head_valid = active && (count != '0);

    assign bus.req_valid = active && !bus.redirect_valid && has_room;
    assign bus.req_pc    = pc_q;
    assign fire          = bus.req_valid && bus.req_ready;
    assign pop_eff       = head_valid && bus.fq_pop;

    assign wdata = {pc_q, bus.pred_valid, bus.pred_valid ? bus.pred_target : {XLEN{1'b0}}};

    always_comb begin
        pc_sel = PcHold;
        if (redirect)  pc_sel = PcRedirect;
        else if (fire) pc_sel = bus.pred_valid ? PcPred : PcSeq;
    end

    always_comb begin
        pc_d = pc_q;
        unique case (pc_sel)
            PcRedirect: pc_d = align(bus.redirect_pc);
            PcPred:     pc_d = align(bus.pred_target);
            PcSeq:      pc_d = pc_q + XLEN'(INST_BYTES);
            PcHold:     pc_d = pc_q;
            default:    pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) pc_q <= RESET_PC;
        else                  pc_q <= pc_d;
    end

    pc_gen_fq_fifo #(
        .Width (EntryW),
        .Depth (FQ_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (fire),
        .wdata_i (wdata),
        .pop_i   (pop_eff),
        .rdata_o (rdata),
        .count_o (count)
    );

    // Head fields read as zero whenever the head is not presentable
    assign bus.fq_valid       = head_valid;
    assign bus.fq_pc          = head_valid ? rdata[EntryW-1 -: XLEN] : '0;
    assign bus.fq_pred_taken  = head_valid ? rdata[XLEN] : 1'b0;
    assign bus.fq_pred_target = head_valid ? rdata[XLEN-1:0] : '0;
    assign bus.fq_count       = count;

endmodule

// File: tb/tb_pc_gen_fq.sv
// Directed table-driven bench for pc_gen_fq: one vector per cycle, outputs checked mid-cycle.
module tb_pc_gen_fq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_gen_fq_if #(.XLEN(32), .FQ_DEPTH(4)) bus ();

    pc_gen_fq #(
        .XLEN       (32),
        .RESET_PC   (32'h0),
        .INST_BYTES (4),
        .FQ_DEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rpc;
        logic        pv;
        logic [31:0] pt;
        logic        rr, pop;
        logic        e_rv;
        logic [31:0] e_pc;
        logic        e_fv;
        logic [31:0] e_fpc;
        logic        e_tk;
        logic [31:0] e_tg;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic pv, input logic [31:0] pt, input logic rr, input logic pop,
                       input logic e_rv, input logic [31:0] e_pc, input logic e_fv,
                       input logic [31:0] e_fpc, input logic e_tk, input logic [31:0] e_tg,
                       input logic [2:0] e_cnt);
        vec_t v;
        v.rst = r;  v.rdy = rdy;  v.rv = rv;  v.rpc = rpc;  v.pv = pv;  v.pt = pt;
        v.rr = rr;  v.pop = pop;  v.e_rv = e_rv;  v.e_pc = e_pc;  v.e_fv = e_fv;
        v.e_fpc = e_fpc;  v.e_tk = e_tk;  v.e_tg = e_tg;  v.e_cnt = e_cnt;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                         input logic pv, input logic [31:0] pt, input logic rr, input logic pop);
        rst                = r;
        bus.rdy            = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.pred_valid     = pv;
        bus.pred_target    = pt;
        bus.req_ready      = rr;
        bus.fq_pop         = pop;
    endtask

    initial begin
        bit timed_out;
        drive(1, 1, 0, 0, 0, 0, 1, 0);
        repeat (2) @(posedge clk);
        #1;

        //   rst rdy rv rpc           pv pt      rr pop | rv pc           fv fpc          tk tg     cnt
        // reset, then 4 sequential fetches fill the queue
        add(1, 1, 0, 32'h0,        0, 32'h0,   1, 0,   0, 32'h0,        0, 32'h0,        0, 32'h0,   0);
        add(0, 1, 0, 32'h0,        0, 32'h0,   1, 0,   1, 32'h0,        0, 32'h0,        0, 32'h0,   0);
        add(0, 1, 0, 32'h0,        0, 32'h0,   1, 0,   1, 32'h4,        1, 32'h0,        0, 32'h0,   1);
        add(0, 1, 0, 32'h0,        0, 32'h0,   1, 0,   1, 32'h8,        1, 32'h0,        0, 32'h0,   2);
        add(0, 1, 0, 32'h0,        0, 32'h0,   1, 0,   1, 32'hC,        1, 32'h0,        0, 32'h0,   3);
        add(0, 1, 0, 32'h0,        0, 32'h0,   1, 0,   0, 32'h10,       1, 32'h0,        0, 32'h0,   4);
        // full: pop only, then push resumes back to 4
        add(0, 1, 0, 32'h0,        0, 32'h0,   1, 1,   0, 32'h10,       1, 32'h0,        0, 32'h0,   4);
        add(0, 1, 0, 32'h0,        0, 32'h0,   1, 0,   1, 32'h10,       1, 32'h4,        0, 32'h0,   3);
        add(0, 1, 0, 32'h0,        0, 32'h0,   1, 0,   0, 32'h14,       1, 32'h4,        0, 32'h0,   4);
        // rdy low: pop and redirect ignored
        add(0, 0, 0, 32'h0,        0, 32'h0,   1, 1,   0, 32'h14,       0, 32'h0,        0, 32'h0,   4);
        add(0, 0, 1, 32'h300,      0, 32'h0,   1, 1,   0, 32'h14,       0, 32'h0,        0, 32'h0,   4);
        add(0, 0, 0, 32'h0,        0, 32'h0,   1, 1,   0, 32'h14,       0, 32'h0,        0, 32'h0,   4);
        add(0, 1, 0, 32'h0,        0, 32'h0,   1, 1,   0, 32'h14,       1, 32'h4,        0, 32'h0,   4);
        add(0, 1, 0, 32'h0,        0, 32'h0,   0, 0,   1, 32'h14,       1, 32'h8,        0, 32'h0,   3);
        // redirect with 3 queued and a pop: flush, aligned restart
        add(0, 1, 1, 32'h203,      0, 32'h0,   1, 1,   0, 32'h14,       1, 32'h8,        0, 32'h0,   3);
        add(0, 1, 0, 32'h0,        0, 32'h0,   1, 1,   1, 32'h200,      0, 32'h0,        0, 32'h0,   0);
        // prediction at pc 0x8
        add(0, 1, 1, 32'h8,        0, 32'h0,   1, 0,   0, 32'h204,      1, 32'h200,      0, 32'h0,   1);
        add(0, 1, 0, 32'h0,        1, 32'h100, 1, 0,   1, 32'h8,        0, 32'h0,        0, 32'h0,   0);
        add(0, 1, 0, 32'h0,        0, 32'h0,   1, 0,   1, 32'h100,      1, 32'h8,        1, 32'h100, 1);
        add(0, 1, 0, 32'h0,        0, 32'h0,   0, 1,   1, 32'h104,      1, 32'h8,        1, 32'h100, 2);
        add(0, 1, 0, 32'h0,        1, 32'h500, 0, 0,   1, 32'h104,      1, 32'h100,      0, 32'h0,   1);
        // pc wraps modulo 2^32
        add(0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,  1, 0,   0, 32'h104,      1, 32'h100,      0, 32'h0,   1);
        add(0, 1, 0, 32'h0,        0, 32'h0,   1, 0,   1, 32'hFFFF_FFFC, 0, 32'h0,       0, 32'h0,   0);
        add(0, 1, 0, 32'h0,        0, 32'h0,   1, 1,   1, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,  1);
        // freeze with room, then reset mid-stream
        add(0, 0, 0, 32'h0,        0, 32'h0,   1, 0,   0, 32'h4,        0, 32'h0,        0, 32'h0,   1);
        add(1, 1, 0, 32'h0,        0, 32'h0,   1, 1,   0, 32'h4,        0, 32'h0,        0, 32'h0,   1);
        add(0, 1, 0, 32'h0,        0, 32'h0,   0, 0,   1, 32'h0,        0, 32'h0,        0, 32'h0,   0);

        foreach (vq[i]) begin
            vec_t v;
            v = vq[i];
            drive(v.rst, v.rdy, v.rv, v.rpc, v.pv, v.pt, v.rr, v.pop);
            #2;
            chk($sformatf("v%0d req_valid", i), 32'(bus.req_valid), 32'(v.e_rv));
            chk($sformatf("v%0d req_pc", i), bus.req_pc, v.e_pc);
            chk($sformatf("v%0d fq_valid", i), 32'(bus.fq_valid), 32'(v.e_fv));
            chk($sformatf("v%0d fq_pc", i), bus.fq_pc, v.e_fpc);
            chk($sformatf("v%0d fq_pred_taken", i), 32'(bus.fq_pred_taken), 32'(v.e_tk));
            chk($sformatf("v%0d fq_pred_target", i), bus.fq_pred_target, v.e_tg);
            chk($sformatf("v%0d fq_count", i), 32'(bus.fq_count), 32'(v.e_cnt));
            @(posedge clk);
            #1;
        end

        // Misaligned predicted target is aligned into pc
        drive(0, 1, 0, 32'h0, 1, 32'h2FE, 1, 0);
        #2;
        chk("pred_align req_valid", 32'(bus.req_valid), 32'h1);
        @(posedge clk);
        #1;
        drive(0, 1, 0, 32'h0, 0, 32'h0, 1, 0);
        #2;
        chk("pred_align req_pc", bus.req_pc, 32'h2FC);
        chk("pred_align fq_pred_taken", 32'(bus.fq_pred_taken), 32'h1);

        // Keep issuing until the queue fills, bounded
        timed_out = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (!bus.req_valid) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            #3;
        end
        chk("fill timeout", 32'(timed_out), 32'h0);
        chk("fill fq_count", 32'(bus.fq_count), 32'h4);
        chk("fill req_pc", bus.req_pc, 32'h308);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
